// File: rtl/regctrl_pkg.sv
// Shared definitions for the register-file access controller: default widths,
// operation codes and controller state encodings.
package regctrl_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned ADDR_W_DEF = 5;

    typedef enum logic [2:0] {
        OpAdd  = 3'b000,
        OpSub  = 3'b001,
        OpAnd  = 3'b010,
        OpOr   = 3'b011,
        OpSlt  = 3'b100,
        OpMove = 3'b101,
        OpRsv6 = 3'b110,
        OpRsv7 = 3'b111
    } op_e;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StRead    = 3'd1,
        StExec    = 3'd2,
        StWbSetup = 3'd3,
        StWbPulse = 3'd4,
        StWbHold  = 3'd5,
        StResp    = 3'd6
    } state_e;

    // Codes 110 and 111 produce no result and never write back.
    function automatic logic op_is_reserved(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/regctrl_alu.sv
// Combinational ALU for the register-file access controller.
// Signed ADD/SUB overflow is only reported when REGCTRL_OVF_EN is defined;
// otherwise ovf_o is constant 0.
module regctrl_alu
    import regctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ovf_o
);

    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] diff;
    logic              slt;

    assign sum  = a_i + b_i;
    assign diff = a_i - b_i;
    assign slt  = $signed(a_i) < $signed(b_i);

    // Decode the operation into a result and, optionally, an overflow flag.
    always_comb begin
        result_o = '0;
        ovf_o    = 1'b0;
        unique case (op_e'(op_i))
            OpAdd: begin
                result_o = sum;
`ifdef REGCTRL_OVF_EN
                ovf_o = (a_i[DATA_W-1] == b_i[DATA_W-1]) &&
                        (sum[DATA_W-1] != a_i[DATA_W-1]);
`endif
            end
            OpSub: begin
                result_o = diff;
`ifdef REGCTRL_OVF_EN
                ovf_o = (a_i[DATA_W-1] != b_i[DATA_W-1]) &&
                        (diff[DATA_W-1] != a_i[DATA_W-1]);
`endif
            end
            OpAnd:   result_o = a_i & b_i;
            OpOr:    result_o = a_i | b_i;
            OpSlt:   result_o = {{(DATA_W-1){1'b0}}, slt};
            OpMove:  result_o = a_i;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file access controller: accepts one command over valid/ready, reads
// two source registers, computes a result and writes it back with a
// setup/pulse/hold strobe sequence before returning a response.
// Optional build macro REGCTRL_OVF_EN: signed ADD/SUB overflow is flagged on
// rsp_ovf and suppresses the write-back.
module regfile_access_ctrl
    import regctrl_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_rs,
    input  logic [ADDR_W-1:0] cmd_rt,
    input  logic [ADDR_W-1:0] cmd_rd,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_wrote,
    output logic              rsp_ovf,
    output logic [ADDR_W-1:0] rf_read_reg1,
    output logic [ADDR_W-1:0] rf_read_reg2,
    input  logic [DATA_W-1:0] rf_read_data1,
    input  logic [DATA_W-1:0] rf_read_data2,
    output logic [ADDR_W-1:0] rf_write_reg,
    output logic [DATA_W-1:0] rf_write_data,
    output logic              rf_regWrite
);

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              ovf_q, ovf_d;

    logic              cmd_ready_q, cmd_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_wrote_q, rsp_wrote_d;
    logic              rsp_ovf_q, rsp_ovf_d;
    logic [ADDR_W-1:0] read_reg1_q, read_reg1_d;
    logic [ADDR_W-1:0] read_reg2_q, read_reg2_d;
    logic [ADDR_W-1:0] write_reg_q, write_reg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;

    logic [DATA_W-1:0] alu_result;
    logic              alu_ovf;
    logic              wb_en;

    // Operands come straight from the register file while in READ.
    regctrl_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .op_i     (op_q),
        .a_i      (rf_read_data1),
        .b_i      (rf_read_data2),
        .result_o (alu_result),
        .ovf_o    (alu_ovf)
    );

    // Write-back is skipped for R0, reserved ops and (when enabled) overflow.
    assign wb_en = (rd_q != '0) && !op_is_reserved(op_q) && !ovf_q;

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        rd_d         = rd_q;
        result_d     = result_q;
        ovf_d        = ovf_q;
        read_reg1_d  = read_reg1_q;
        read_reg2_d  = read_reg2_q;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;
        rsp_result_d = rsp_result_q;
        rsp_wrote_d  = rsp_wrote_q;
        rsp_ovf_d    = rsp_ovf_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid && cmd_ready_q) begin
                    state_d     = StRead;
                    op_d        = cmd_op;
                    rd_d        = cmd_rd;
                    read_reg1_d = cmd_rs;
                    read_reg2_d = cmd_rt;
                end
            end
            StRead: begin
                // Operands are sampled here, before any write-back to rd.
                state_d  = StExec;
                result_d = alu_result;
                ovf_d    = alu_ovf;
            end
            StExec: begin
                if (wb_en) begin
                    state_d      = StWbSetup;
                    write_reg_d  = rd_q;
                    write_data_d = result_q;
                end else begin
                    state_d = StResp;
                end
            end
            StWbSetup: state_d = StWbPulse;
            StWbPulse: state_d = StWbHold;
            StWbHold:  state_d = StResp;
            StResp: begin
                if (rsp_valid_q && rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Response fields are latched once on entry to RESP and then held.
        if (state_d == StResp && state_q != StResp) begin
            rsp_result_d = result_q;
            rsp_wrote_d  = (state_q == StWbHold);
            rsp_ovf_d    = ovf_q;
        end

        cmd_ready_d = (state_d == StIdle);
        rsp_valid_d = (state_d == StResp);
        reg_write_d = (state_d == StWbPulse);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            op_q         <= '0;
            rd_q         <= '0;
            result_q     <= '0;
            ovf_q        <= 1'b0;
            cmd_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_wrote_q  <= 1'b0;
            rsp_ovf_q    <= 1'b0;
            read_reg1_q  <= '0;
            read_reg2_q  <= '0;
            write_reg_q  <= '0;
            write_data_q <= '0;
            reg_write_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            rd_q         <= rd_d;
            result_q     <= result_d;
            ovf_q        <= ovf_d;
            cmd_ready_q  <= cmd_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_wrote_q  <= rsp_wrote_d;
            rsp_ovf_q    <= rsp_ovf_d;
            read_reg1_q  <= read_reg1_d;
            read_reg2_q  <= read_reg2_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign cmd_ready     = cmd_ready_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_result    = rsp_result_q;
    assign rsp_wrote     = rsp_wrote_q;
    assign rsp_ovf       = rsp_ovf_q;
    assign rf_read_reg1  = read_reg1_q;
    assign rf_read_reg2  = read_reg2_q;
    assign rf_write_reg  = write_reg_q;
    assign rf_write_data = write_data_q;
    assign rf_regWrite   = reg_write_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Directed bench for regfile_access_ctrl with a behavioural register file.
// Expected results follow REGCTRL_OVF_EN when the bench is built with it.
module tb_regfile_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_wrote;
    logic        rsp_ovf;
    logic [4:0]  rf_read_reg1, rf_read_reg2, rf_write_reg;
    logic [31:0] rf_read_data1, rf_read_data2, rf_write_data;
    logic        rf_regWrite;

    int total = 0;
    int bad   = 0;
    int pulses = 0;

    // Behavioural register file: level write strobe sampled at the clock.
    logic [31:0] rf [32];
    logic        poke_en;
    logic [4:0]  poke_addr;
    logic [31:0] poke_data;

    assign rf_read_data1 = rf[rf_read_reg1];
    assign rf_read_data2 = rf[rf_read_reg2];

    always @(posedge clk) begin
        if (poke_en) rf[poke_addr] <= poke_data;
        else if (rf_regWrite) rf[rf_write_reg] <= rf_write_data;
        if (rf_regWrite) pulses <= pulses + 1;
    end

    regfile_access_ctrl #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_op        (cmd_op),
        .cmd_rs        (cmd_rs),
        .cmd_rt        (cmd_rt),
        .cmd_rd        (cmd_rd),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_wrote     (rsp_wrote),
        .rsp_ovf       (rsp_ovf),
        .rf_read_reg1  (rf_read_reg1),
        .rf_read_reg2  (rf_read_reg2),
        .rf_read_data1 (rf_read_data1),
        .rf_read_data2 (rf_read_data2),
        .rf_write_reg  (rf_write_reg),
        .rf_write_data (rf_write_data),
        .rf_regWrite   (rf_regWrite)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic poke(input logic [4:0] a, input logic [31:0] d);
        poke_en   = 1'b1;
        poke_addr = a;
        poke_data = d;
        tick();
        poke_en = 1'b0;
    endtask

    // Handshake at edge N; returns at the negedge of cycle N+1 (READ).
    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd);
        chk("send.ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rs    = rs;
        cmd_rt    = rt;
        cmd_rd    = rd;
        tick();
        cmd_valid = 1'b0;
    endtask

    // Walks cycles N+1 .. RESP, optionally back-pressures, then completes.
    task automatic follow(input string tag, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic wb, input logic [31:0] res,
                          input logic ovf, input int hold);
        int lat;
        int p0;
        lat = wb ? 6 : 3;
        p0  = pulses;
        for (int c = 1; c <= lat; c++) begin
            if (c > 1) tick();
            chk({tag, ".we"}, rf_regWrite, (wb && c == 4));
            chk({tag, ".vld"}, rsp_valid, (c == lat));
            if (c == 1) begin
                chk({tag, ".rreg1"}, rf_read_reg1, rs);
                chk({tag, ".rreg2"}, rf_read_reg2, rt);
            end
            if (wb && c >= 3 && c <= 5) begin
                chk({tag, ".wreg"}, rf_write_reg, rd);
                chk({tag, ".wdata"}, rf_write_data, res);
            end
        end
        chk({tag, ".result"}, rsp_result, res);
        chk({tag, ".wrote"}, rsp_wrote, wb);
        chk({tag, ".ovf"}, rsp_ovf, ovf);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            tick();
            chk({tag, ".hold_vld"}, rsp_valid, 1'b1);
            chk({tag, ".hold_res"}, rsp_result, res);
            chk({tag, ".hold_rdy"}, cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, ".done_vld"}, rsp_valid, 1'b0);
        chk({tag, ".done_rdy"}, cmd_ready, 1'b1);
        chk({tag, ".pulses"}, pulses - p0, wb ? 1 : 0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_rs    = 5'd0;
        cmd_rt    = 5'd0;
        cmd_rd    = 5'd0;
        rsp_ready = 1'b0;
        poke_en   = 1'b0;
        poke_addr = 5'd0;
        poke_data = 32'd0;

        // Preload the register file while the controller is in reset.
        for (int i = 0; i < 32; i++) poke(5'(i), 32'd0);
        poke(5'd1, 32'h0000_3000);
        poke(5'd2, 32'h0000_0005);
        poke(5'd4, 32'hFFFF_FFFF);
        poke(5'd7, 32'h7FFF_FFFF);
        poke(5'd8, 32'h0000_0001);

        chk("rst.ready", cmd_ready, 1'b0);
        chk("rst.we", rf_regWrite, 1'b0);
        chk("rst.vld", rsp_valid, 1'b0);
        chk("rst.result", rsp_result, 32'd0);
        chk("rst.wdata", rf_write_data, 32'd0);

        rst_n = 1'b1;
        tick();
        chk("idle.ready", cmd_ready, 1'b1);

        // ADD R1+R2 -> R3
        send(3'b000, 5'd1, 5'd2, 5'd3);
        follow("add", 5'd1, 5'd2, 5'd3, 1'b1, 32'h0000_3005, 1'b0, 0);
        chk("add.r3", rf[3], 32'h0000_3005);

        // MOVE to R0: no write-back
        send(3'b101, 5'd1, 5'd0, 5'd0);
        follow("move0", 5'd1, 5'd0, 5'd0, 1'b0, 32'h0000_3000, 1'b0, 0);
        chk("move0.r0", rf[0], 32'd0);

        // SUB R1-R2 -> R11
        send(3'b001, 5'd1, 5'd2, 5'd11);
        follow("sub", 5'd1, 5'd2, 5'd11, 1'b1, 32'h0000_2FFB, 1'b0, 0);
        chk("sub.r11", rf[11], 32'h0000_2FFB);

        // AND R1&R3 -> R16
        send(3'b010, 5'd1, 5'd3, 5'd16);
        follow("and", 5'd1, 5'd3, 5'd16, 1'b1, 32'h0000_3000, 1'b0, 0);
        chk("and.r16", rf[16], 32'h0000_3000);

        // OR R1|R2 -> R12
        send(3'b011, 5'd1, 5'd2, 5'd12);
        follow("or", 5'd1, 5'd2, 5'd12, 1'b1, 32'h0000_3005, 1'b0, 0);
        chk("or.r12", rf[12], 32'h0000_3005);

        // rs == rd: ADD R3+R3 -> R3 uses the old R3
        send(3'b000, 5'd3, 5'd3, 5'd3);
        follow("addself", 5'd3, 5'd3, 5'd3, 1'b1, 32'h0000_600A, 1'b0, 0);
        chk("addself.r3", rf[3], 32'h0000_600A);

        // SLT signed: -1 < 5 -> 1, and 5 < -1 -> 0
        send(3'b100, 5'd4, 5'd2, 5'd6);
        follow("slt1", 5'd4, 5'd2, 5'd6, 1'b1, 32'd1, 1'b0, 0);
        chk("slt1.r6", rf[6], 32'd1);
        poke(5'd17, 32'h0000_00AA);
        send(3'b100, 5'd2, 5'd4, 5'd17);
        follow("slt0", 5'd2, 5'd4, 5'd17, 1'b1, 32'd0, 1'b0, 0);
        chk("slt0.r17", rf[17], 32'd0);

        // Reserved op: result 0, no write-back
        send(3'b111, 5'd1, 5'd2, 5'd10);
        follow("rsv", 5'd1, 5'd2, 5'd10, 1'b0, 32'd0, 1'b0, 0);
        chk("rsv.r10", rf[10], 32'd0);

        // Signed overflow on ADD
        send(3'b000, 5'd7, 5'd8, 5'd9);
`ifdef REGCTRL_OVF_EN
        follow("ovf", 5'd7, 5'd8, 5'd9, 1'b0, 32'h8000_0000, 1'b1, 0);
        chk("ovf.r9", rf[9], 32'd0);
`else
        follow("ovf", 5'd7, 5'd8, 5'd9, 1'b1, 32'h8000_0000, 1'b0, 0);
        chk("ovf.r9", rf[9], 32'h8000_0000);
`endif

        // Back-pressure with a second command already offered
        send(3'b000, 5'd2, 5'd2, 5'd13);
        cmd_valid = 1'b1;
        cmd_op    = 3'b110;
        cmd_rs    = 5'd13;
        cmd_rt    = 5'd1;
        cmd_rd    = 5'd0;
        follow("bp", 5'd2, 5'd2, 5'd13, 1'b1, 32'h0000_000A, 1'b0, 5);
        tick();
        cmd_valid = 1'b0;
        chk("bp2.ready", cmd_ready, 1'b0);
        follow("bp2", 5'd13, 5'd1, 5'd0, 1'b0, 32'd0, 1'b0, 0);

        // Reset during the write pulse
        send(3'b000, 5'd1, 5'd2, 5'd15);
        tick();
        tick();
        tick();
        chk("rstwb.pulse", rf_regWrite, 1'b1);
        rst_n = 1'b0;
        tick();
        chk("rstwb.we", rf_regWrite, 1'b0);
        chk("rstwb.vld", rsp_valid, 1'b0);
        chk("rstwb.ready", cmd_ready, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rstwb.novld", rsp_valid, 1'b0);
            chk("rstwb.nowe", rf_regWrite, 1'b0);
        end
        chk("rstwb.idle", cmd_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_access_ctrl.md
Name: regfile_access_ctrl

Overview:
- Initiator/master side of the `register_block` port set (read_reg1/2, read_data1/2, write_reg, write_data, regWrite).
- Accepts one register-transfer command at a time over valid/ready:
  - drives the register file read addresses;
  - captures the operands;
  - computes a simple result;
  - performs a write-back with a setup/pulse/hold sequence on `regWrite`, which the register file treats as a level-sensitive write strobe.
- Sits between the command issuer (future control unit / debug sequencer) and `register_block`.

Parameters:
- DATA_W, 32, register data width
- ADDR_W, 5, register index width (32 registers)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  controller can accept a command
- cmd_op  in  3  operation code
- cmd_rs  in  ADDR_W  source register 1
- cmd_rt  in  ADDR_W  source register 2
- cmd_rd  in  ADDR_W  destination register
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumed
- rsp_result  out  DATA_W  computed result
- rsp_wrote  out  1  1 = write-back performed
- rsp_ovf  out  1  signed overflow flag (see Optional Feature)
- rf_read_reg1  out  ADDR_W  to register_block read_reg1
- rf_read_reg2  out  ADDR_W  to register_block read_reg2
- rf_read_data1  in  DATA_W  from register_block read_data1
- rf_read_data2  in  DATA_W  from register_block read_data2
- rf_write_reg  out  ADDR_W  to register_block write_reg
- rf_write_data  out  DATA_W  to register_block write_data
- rf_regWrite  out  1  to register_block regWrite, level write strobe

Behaviour:
- Reset:
  - rst_n=0 sampled at a clk edge puts state in IDLE.
  - All outputs go to 0, including cmd_ready=0 while rst_n=0 and rf_regWrite=0.
  - Reset asserted mid-write-back drops rf_regWrite at that same edge; the interrupted command produces no response.
- All outputs are registered. cmd_ready=1 only in IDLE with rst_n=1.
- Op codes:
  - 000 ADD: rs+rt, mod 2^DATA_W
  - 001 SUB: rs-rt
  - 010 AND
  - 011 OR
  - 100 SLT: signed rs<rt gives 1, else 0
  - 101 MOVE: rs
  - 110/111 reserved: result 0, no write-back
- States: IDLE, READ, EXEC, WB_SETUP, WB_PULSE, WB_HOLD, RESP.
- Timeline, handshake at edge N:
  - N+1 READ: rf_read_reg1=rs, rf_read_reg2=rt. rf_read_data1/2 are sampled at the end of READ.
  - N+2 EXEC: result registered.
  - N+3 WB_SETUP: rf_write_reg=rd, rf_write_data=result, rf_regWrite=0.
  - N+4 WB_PULSE: rf_regWrite=1 for exactly one cycle.
  - N+5 WB_HOLD: rf_regWrite=0, address and data unchanged.
  - N+6 RESP.
- Write-back is skipped (EXEC goes directly to RESP at N+3) when any of these holds:
  - rd==0;
  - op is reserved;
  - op is ADD/SUB and overflow is detected with the feature enabled.
- RESP: rsp_valid=1 and rsp_result/rsp_wrote are held stable until rsp_ready=1. At that edge the state returns to IDLE and rsp_valid=0. rsp_ready=1 on the first RESP cycle gives a single-cycle rsp_valid.
- No overlap: a new command is accepted at the earliest one cycle after response completion.
- rf_read_reg*, rf_write_reg and rf_write_data hold their last values outside their states. rf_regWrite is 1 only in WB_PULSE.
- cmd_rs==cmd_rd is legal: operands are captured before the write.

Optional Feature:
- Macro: REGCTRL_OVF_EN.
- Defined:
  - ADD/SUB signed overflow sets rsp_ovf=1 and suppresses the write-back (rsp_wrote=0).
  - rsp_result still returns the wrapped sum.
- Undefined: rsp_ovf is tied to 0 and ADD/SUB always write back.

Decomposition:
- Shared package/include regctrl_pkg holds:
  - op-code constants;
  - state encodings;
  - default DATA_W/ADDR_W.
- One natural sub-module: regctrl_alu, purely combinational: op, a, b giving result and ovf.
- FSM and port registers stay in the top module.

Test Plan:
- Bench uses a behavioural register_block model, preloaded with R1=0x3000 and R2=0x0005.
- ADD rs=1 rt=2 rd=3 -> rf_regWrite high only at N+4 with rf_write_reg=3 and rf_write_data=0x3005; rsp_valid at N+6 with result 0x3005, wrote=1.
- MOVE rs=1 rd=0 -> no rf_regWrite pulse; rsp_valid at N+3 with result 0x3000, wrote=0; R0 still 0.
- SLT with R4=0xFFFFFFFF, R2=5, rd=6 -> R6=1. op=111 -> result 0, wrote=0.
- ADD with R7=0x7FFFFFFF and R8=1, rd=9:
  - with REGCTRL_OVF_EN: rsp_ovf=1, wrote=0, R9 unchanged;
  - without it: R9=0x80000000, ovf=0.
- Hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_result stable, cmd_ready=0, a second cmd_valid is not accepted until one cycle after rsp_ready.
- Assert rst_n=0 during WB_PULSE -> rf_regWrite=0 at the next edge; state IDLE; rsp_valid never asserts.
